// File: rtl/t05_bitsched_pkg.sv
// Shared types and default sizing for the bitstream scheduler.
package t05_bitsched_pkg;

  localparam int unsigned DEF_WORD_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CB,
    FLUSH,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/t05_bit_packer.sv
// MSB-first bit packer with a single holding register on a valid/ready output.
// The caller must not present a word-completing bit or a pad request unless hold_free_c is high.
module t05_bit_packer
  import t05_bitsched_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_acc,
  input  logic              pad,
  input  logic              wr_ready,
  output logic [WORD_W-1:0] wr_data,
  output logic              wr_valid,
  output logic              stall_c,
  output logic              partial_c,
  output logic              hold_free_c
);

  localparam int unsigned BC_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] pack;
  logic [BC_W-1:0]   bit_cnt;
  logic              last_c;
  logic [WORD_W-1:0] shifted_c;
  logic [WORD_W-1:0] pad_word_c;

  assign last_c      = (bit_cnt == BC_W'(WORD_W - 1));
  assign shifted_c   = {pack[WORD_W-2:0], in_bit};
  // Left-justify the partial word so the oldest bit lands in the MSB, zeros below.
  assign pad_word_c  = pack << (BC_W'(WORD_W) - bit_cnt);
  assign hold_free_c = !wr_valid || wr_ready;
  assign stall_c     = last_c && wr_valid && !wr_ready;
  assign partial_c   = (bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pack     <= '0;
      bit_cnt  <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
    end else if (in_acc && last_c) begin
      wr_data  <= shifted_c;
      wr_valid <= 1'b1;
      pack     <= '0;
      bit_cnt  <= '0;
    end else if (pad) begin
      wr_data  <= pad_word_c;
      wr_valid <= 1'b1;
      pack     <= '0;
      bit_cnt  <= '0;
    end else begin
      if (in_acc) begin
        pack    <= shifted_c;
        bit_cnt <= bit_cnt + BC_W'(1);
      end
      if (wr_valid && wr_ready) wr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/t05_bitstream_scheduler.sv
// Arbitrates header and codeword bit sources into a packed word stream with flush/drain.
// Optional total-bit counter enabled by defining T05_BITSCHED_BITCOUNT_EN.
module t05_bitstream_scheduler
  import t05_bitsched_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hdr_bit,
  input  logic              hdr_en,
  input  logic              hdr_finish,
  input  logic              cb_bit,
  input  logic              cb_en,
  input  logic              cb_finish,
  output logic              hdr_grant,
  output logic              cb_grant,
  input  logic              eos,
  output logic [WORD_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              done,
  output logic [CNT_W-1:0]  total_bits
);

  state_e state;
  logic   stall_c;
  logic   partial_c;
  logic   hold_free_c;
  logic   hdr_acc_c;
  logic   cb_acc_c;
  logic   acc_c;
  logic   acc_bit_c;
  logic   hdr_fin_c;
  logic   cb_fin_c;
  logic   pad_c;

  // Grants are combinational so back-pressure reacts to wr_ready in the same cycle.
  always_comb begin
    hdr_grant = 1'b0;
    cb_grant  = 1'b0;
    if (!stall_c) begin
      hdr_grant = (state == IDLE) || (state == HDR);
      cb_grant  = (state == IDLE) || (state == CB);
    end
  end

  assign hdr_acc_c = hdr_en && hdr_grant;
  assign cb_acc_c  = cb_en && cb_grant && ((state == CB) || ((state == IDLE) && !hdr_en));
  assign acc_c     = hdr_acc_c || cb_acc_c;
  assign acc_bit_c = hdr_acc_c ? hdr_bit : cb_bit;
  // A finish travelling with a stalled bit waits until that bit is taken.
  assign hdr_fin_c = hdr_finish && (!hdr_en || hdr_grant);
  assign cb_fin_c  = cb_finish && (!cb_en || cb_grant);
  assign pad_c     = (state == FLUSH) && partial_c && hold_free_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hdr_en)     state <= hdr_fin_c ? IDLE : HDR;
          else if (cb_en) state <= cb_fin_c ? IDLE : CB;
          else if (eos)   state <= FLUSH;
        end
        HDR:   if (hdr_fin_c) state <= IDLE;
        CB:    if (cb_fin_c) state <= IDLE;
        FLUSH: if (!partial_c || hold_free_c) state <= DRAIN;
        DRAIN: begin
          if (!wr_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  t05_bit_packer #(.WORD_W(WORD_W)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .in_bit      (acc_bit_c),
    .in_acc      (acc_c),
    .pad         (pad_c),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .stall_c     (stall_c),
    .partial_c   (partial_c),
    .hold_free_c (hold_free_c)
  );

`ifdef T05_BITSCHED_BITCOUNT_EN
  logic [CNT_W-1:0] bit_total;

  // Saturating count of accepted payload bits; pad bits never pass through acc_c.
  always_ff @(posedge clk) begin
    if (rst)                           bit_total <= '0;
    else if (acc_c && (bit_total != '1)) bit_total <= bit_total + CNT_W'(1);
  end

  assign total_bits = bit_total;
`else
  assign total_bits = '0;
`endif

endmodule

// File: tb/tb_t05_bitstream_scheduler.sv
// Scoreboard bench for t05_bitstream_scheduler: expected words queued at stimulus time, checked on transfer.
module tb_t05_bitstream_scheduler;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              hdr_bit, hdr_en, hdr_finish;
  logic              cb_bit, cb_en, cb_finish;
  logic              hdr_grant, cb_grant;
  logic              eos;
  logic [WORD_W-1:0] wr_data;
  logic              wr_valid, wr_ready;
  logic              done;
  logic [CNT_W-1:0]  total_bits;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_total = 0;
  int          done_cnt = 0;
  int          xfer_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  t05_bitstream_scheduler #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .hdr_bit    (hdr_bit),
    .hdr_en     (hdr_en),
    .hdr_finish (hdr_finish),
    .cb_bit     (cb_bit),
    .cb_en      (cb_en),
    .cb_finish  (cb_finish),
    .hdr_grant  (hdr_grant),
    .cb_grant   (cb_grant),
    .eos        (eos),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .done       (done),
    .total_bits (total_bits)
  );

  always #5 clk = ~clk;

  // Transfers are sampled mid-cycle; the values seen here are what the next rising edge commits.
  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) begin
      xfer_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected got=%h required=none", wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (wr_data !== mon_exp) begin
          n_fail++;
          $display("FAIL word_data got=%h required=%h", wr_data, mon_exp);
        end
      end
    end
    if (!rst && done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic int exp_tot();
`ifdef T05_BITSCHED_BITCOUNT_EN
    return exp_total;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one bit (and optional finish) and holds it until the source is granted.
  task automatic drive_bit(input logic is_hdr, input logic b, input logic fin);
    int t;
    t = 0;
    if (is_hdr) begin hdr_en = 1'b1; hdr_bit = b; hdr_finish = fin; end
    else        begin cb_en  = 1'b1; cb_bit  = b; cb_finish  = fin; end
    @(negedge clk);
    while (!(is_hdr ? hdr_grant : cb_grant) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout got=grant_low required=grant_high src_hdr=%b", is_hdr);
    end else begin
      exp_total++;
    end
    @(posedge clk);
    #1;
    if (is_hdr) begin hdr_en = 1'b0; hdr_finish = 1'b0; end
    else        begin cb_en  = 1'b0; cb_finish  = 1'b0; end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_total = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got=%b required=0", wr_valid); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b required=0", done); end
    n_checks++; if (total_bits !== 16'h0) begin n_fail++; $display("FAIL reset_total got=%0d required=0", total_bits); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got=%h required=00", wr_data); end
    n_checks++; if (hdr_grant !== 1'b1 || cb_grant !== 1'b1) begin
      n_fail++; $display("FAIL reset_grants got=%b%b required=11", hdr_grant, cb_grant);
    end
  endtask

  task automatic test_header_only();
    logic [7:0] pat;
    int x0;
    pat = 8'b1011_0010;
    wr_ready = 1'b1;
    x0 = xfer_cnt;
    exp_q.push_back(8'hB2);
    for (int i = 7; i >= 0; i--) drive_bit(1'b1, pat[i], i == 0);
    repeat (3) tick();
    n_checks++; if (xfer_cnt - x0 !== 1) begin n_fail++; $display("FAIL hdr_word_count got=%0d required=1", xfer_cnt - x0); end
    n_checks++; if (hdr_grant !== 1'b1 || cb_grant !== 1'b1) begin
      n_fail++; $display("FAIL hdr_back_to_idle got=%b%b required=11", hdr_grant, cb_grant);
    end
    n_checks++; if (total_bits !== 16'(exp_tot())) begin
      n_fail++; $display("FAIL hdr_total got=%0d required=%0d", total_bits, exp_tot());
    end
  endtask

  task automatic test_tie();
    logic [7:0] pat;
    pat = 8'h9D;
    wr_ready = 1'b1;
    exp_q.push_back(8'h9D);
    cb_en = 1'b1; cb_bit = 1'b1; cb_finish = 1'b1;
    drive_bit(1'b1, pat[7], 1'b0);
    n_checks++; if (cb_grant !== 1'b0 || hdr_grant !== 1'b1) begin
      n_fail++; $display("FAIL tie_lock got=%b%b required=10", hdr_grant, cb_grant);
    end
    for (int i = 6; i >= 0; i--) begin
      drive_bit(1'b1, pat[i], i == 0);
      if (i == 3) begin
        n_checks++; if (cb_grant !== 1'b0) begin n_fail++; $display("FAIL tie_cb_held_off got=%b required=0", cb_grant); end
      end
    end
    cb_en = 1'b0; cb_finish = 1'b0; cb_bit = 1'b0;
    repeat (3) tick();
    n_checks++; if (cb_grant !== 1'b1) begin n_fail++; $display("FAIL tie_release got=%b required=1", cb_grant); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL tie_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_back_pressure();
    int x0;
    wr_ready = 1'b0;
    x0 = xfer_cnt;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 15; i++) drive_bit(1'b1, 1'b1, 1'b0);
    n_checks++; if (hdr_grant !== 1'b0) begin n_fail++; $display("FAIL bp_grant_drop got=%b required=0", hdr_grant); end
    n_checks++; if (wr_valid !== 1'b1 || wr_data !== 8'hFF) begin
      n_fail++; $display("FAIL bp_first_word got=%b/%h required=1/ff", wr_valid, wr_data);
    end
    repeat (4) tick();
    n_checks++; if (wr_data !== 8'hFF || hdr_grant !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold_stable got=%h/%b required=ff/0", wr_data, hdr_grant);
    end
    wr_ready = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b1);
    n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reload_valid got=%b required=1", wr_valid); end
    repeat (3) tick();
    n_checks++; if (xfer_cnt - x0 !== 2) begin n_fail++; $display("FAIL bp_word_count got=%0d required=2", xfer_cnt - x0); end
    n_checks++; if (total_bits !== 16'(exp_tot())) begin
      n_fail++; $display("FAIL bp_total got=%0d required=%0d", total_bits, exp_tot());
    end
  endtask

  task automatic test_flush();
    int x0;
    apply_reset();
    wr_ready = 1'b1;
    exp_q.push_back(8'hE0);
    drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b1);
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_early_word got=%b required=0", wr_valid); end
    done_cnt = 0;
    eos = 1'b1;
    tick();
    eos = 1'b0;
    n_checks++; if (hdr_grant !== 1'b0 || cb_grant !== 1'b0) begin
      n_fail++; $display("FAIL flush_grants_low got=%b%b required=00", hdr_grant, cb_grant);
    end
    repeat (10) tick();
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL flush_done_pulses got=%0d required=1", done_cnt); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL flush_word_pending got=%0d required=0", exp_q.size()); end
    n_checks++; if (total_bits !== 16'(exp_tot())) begin
      n_fail++; $display("FAIL flush_total got=%0d required=%0d", total_bits, exp_tot());
    end
    // Empty flush: nothing partial, so no word, just the done pulse.
    x0 = xfer_cnt;
    done_cnt = 0;
    eos = 1'b1;
    tick();
    eos = 1'b0;
    repeat (10) tick();
    n_checks++; if (done_cnt !== 1 || xfer_cnt !== x0) begin
      n_fail++; $display("FAIL empty_flush got=done%0d/words%0d required=done1/words0", done_cnt, xfer_cnt - x0);
    end
    n_checks++; if (hdr_grant !== 1'b1 || cb_grant !== 1'b1) begin
      n_fail++; $display("FAIL flush_back_to_idle got=%b%b required=11", hdr_grant, cb_grant);
    end
  endtask

  task automatic test_reset_mid_handshake();
    logic [7:0] pat;
    int x0;
    pat = 8'hA5;
    wr_ready = 1'b0;
    for (int i = 7; i >= 0; i--) drive_bit(1'b1, pat[i], i == 0);
    tick();
    n_checks++; if (wr_valid !== 1'b1 || wr_data !== 8'hA5) begin
      n_fail++; $display("FAIL rmid_pending got=%b/%h required=1/a5", wr_valid, wr_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_total = 0;
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_valid got=%b required=0", wr_valid); end
    n_checks++; if (total_bits !== 16'h0) begin n_fail++; $display("FAIL rmid_total got=%0d required=0", total_bits); end
    n_checks++; if (hdr_grant !== 1'b1 || cb_grant !== 1'b1) begin
      n_fail++; $display("FAIL rmid_idle got=%b%b required=11", hdr_grant, cb_grant);
    end
    x0 = xfer_cnt;
    wr_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (xfer_cnt !== x0) begin n_fail++; $display("FAIL rmid_discarded got=%0d required=0", xfer_cnt - x0); end
  endtask

  initial begin
    rst = 1'b1;
    hdr_bit = 1'b0; hdr_en = 1'b0; hdr_finish = 1'b0;
    cb_bit = 1'b0; cb_en = 1'b0; cb_finish = 1'b0;
    eos = 1'b0;
    wr_ready = 1'b0;
    test_reset();
    test_header_only();
    test_tie();
    test_back_pressure();
    test_flush();
    test_reset_mid_handshake();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL final_scoreboard got=%0d required=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/t05_bitstream_scheduler.md
T05_BITSTREAM_SCHEDULER -- requirements
Module: t05_bitstream_scheduler

Interface
REQ-001 Parameter: WORD_W, 8, packed output word width in bits (legal range 2..16).
REQ-002 Parameter: CNT_W, 16, width of the total-bit counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: hdr_bit / hdr_en / hdr_finish  input  1 each  header-synthesis bit, bit-valid, segment-done pulse.
REQ-006 Port: cb_bit / cb_en / cb_finish  input  1 each  codeword-encoder bit, bit-valid, segment-done pulse.
REQ-007 Port: hdr_grant / cb_grant  output  1 each  source may present bits; a bit is accepted only when en && grant are both high.
REQ-008 Port: eos  input  1  end-of-stream pulse from top control.
REQ-009 Port: wr_data  output  WORD_W  packed word, first accepted bit in the MSB.
REQ-010 Port: wr_valid / wr_ready  output / input  1 each  word handshake; transfer occurs when both are high.
REQ-011 Port: done  output  1  one-cycle pulse when the stream is fully drained.
REQ-012 Port: total_bits  output  CNT_W  payload bits accepted since reset, excluding pad bits.

Function
REQ-013 FSM states: IDLE, HDR, CB, FLUSH, DRAIN, DONE.
REQ-014 IDLE -> HDR on hdr_en; IDLE -> CB on cb_en && !hdr_en; header wins a same-cycle tie.
REQ-015 In IDLE, grant is high for both sources; only the winner's bit is accepted that cycle.
REQ-016 In HDR only hdr_grant may be high; in CB only cb_grant may be high. The lock is held until the locked source's finish pulse.
REQ-017 HDR or CB -> IDLE on the locked source's finish; a bit and finish in the same cycle both count.
REQ-018 The non-locked source's en, bit and finish are ignored while another source is locked.
REQ-019 Packing: accepted bits shift into the pack register MSB-first; bit_cnt increments; at WORD_W bits, the word moves to the holding register, wr_valid rises the next cycle, and bit_cnt returns to 0.
REQ-020 Back-pressure: grant is forced low when bit_cnt == WORD_W-1 && wr_valid && !wr_ready; no bit is ever dropped or overwritten.
REQ-021 Word completion in the same cycle as a handshake: the holding register reloads and wr_valid stays high.
REQ-022 wr_data is stable while wr_valid && !wr_ready.
REQ-023 eos is accepted only in IDLE; any state -> FLUSH on eos is ignored elsewhere, and top control must retry.
REQ-024 FLUSH: if bit_cnt > 0, pad with 0 bits to WORD_W in a single cycle and move the word to the holding register once it is free, then go to DRAIN; if bit_cnt == 0, go directly to DRAIN.
REQ-025 DRAIN -> DONE when the holding register is empty. DONE pulses done for 1 cycle, then returns to IDLE.
REQ-026 In FLUSH, DRAIN and DONE, both grants are low.
REQ-027 total_bits increments per accepted bit and saturates at all-ones.

Reset
REQ-028 On rst: state IDLE, bit_cnt 0, pack and holding registers 0, wr_valid 0, done 0, total_bits 0; grants follow REQ-015 on the cycle after reset.
REQ-029 rst has priority over all inputs; a word pending mid-handshake is discarded.

Configuration
REQ-030 Macro T05_BITSCHED_BITCOUNT_EN: when defined, total_bits behaves per REQ-027.
REQ-031 When T05_BITSCHED_BITCOUNT_EN is undefined, total_bits is tied to 0, no counter flops exist, and all other behaviour is identical.

Structure
REQ-032 Package t05_bitsched_pkg holds the state enum type and the default WORD_W and CNT_W constants.
REQ-033 Sub-module t05_bit_packer holds the pack shift register, bit_cnt, holding register and wr_valid/wr_ready logic; the FSM and arbitration stay in the top module.

Verification
REQ-034 Header only: hdr_en with bits 1,0,1,1,0,0,1,0, then hdr_finish -> wr_data=8'hB2 with one wr_valid pulse, state returns to IDLE.
REQ-035 Tie: hdr_en and cb_en high in the same IDLE cycle -> hdr bit accepted and cb_grant low until hdr_finish.
REQ-036 Back-pressure: wr_ready=0 and 16 header bits of all ones offered -> first word 8'hFF held, grant drops after bit 15, no loss; wr_ready=1 -> second 8'hFF follows.
REQ-037 Flush: 3 bits 1,1,1 then eos -> wr_data=8'hE0 transferred, done pulses once, total_bits=3.
REQ-038 Reset mid-handshake: rst while wr_valid=1 -> next cycle wr_valid=0, total_bits=0, state IDLE.
REQ-039 Macro off: repeat REQ-037 -> wr_data=8'hE0 and total_bits stays 0.
